// File: rtl/usb_ep_regfile.sv
// USB endpoint register file: byte-serialised data buffer, status/error, TX sequencer, flush.
// Optional interrupt mask and irq output under USB_EP_REGFILE_IRQ_EN.
module usb_ep_regfile #(
    parameter int BUF_DEPTH  = 64,
    parameter int TX_TIMEOUT = 255,
    parameter int OCC_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [3:0]       addr,
    input  logic [1:0]       size,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    output logic             hold,
    input  logic [2:0]       rx_packet,
    input  logic             rx_data_ready,
    input  logic             rx_transfer_active,
    input  logic             rx_error,
    input  logic             tx_transfer_active,
    input  logic             tx_error,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic [7:0]       rx_data,
    output logic             get_rx_data,
    output logic             store_tx_data,
    output logic [7:0]       tx_data,
    output logic [2:0]       tx_packet,
    output logic             clear,
    output logic             d_mode
`ifdef USB_EP_REGFILE_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int TMR_W = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [1:0] {B_IDLE, B_XFER, B_DONE} buf_state_e;
    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_BUSY} tx_state_e;

    buf_state_e       bst_q, bst_d;
    logic [1:0]       k_q, k_d;
    logic [1:0]       last_q, last_d;
    logic             wr_q, wr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rv_q, rv_d;
    logic [4:0]       st_q, st_d;
    logic [15:0]      err_q, err_d;
    tx_state_e        tst_q, tst_d;
    logic [7:0]       txc_q, txc_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0]       fl_q, fl_d;
    logic             clr_q, clr_d;
`ifdef USB_EP_REGFILE_IRQ_EN
    logic [15:0]      mask_q, mask_d;
    logic             irq_q, irq_d;
`endif

    logic        acc_ok, buf_req, reg_rd, reg_wr;
    logic        xfer, fl_act, in_rng, last_byte;
    logic        underrun, overflow, tx_tmo;
    logic [7:0]  rd_byte;
    logic [15:0] status, err_set, err_clr;
    logic [31:0] reg_rdata;

    // A request is only accepted while no buffer transfer is stalling the bus
    assign acc_ok  = (bst_q != B_XFER);
    assign buf_req = acc_ok & (rd_en | wr_en) & (addr == 4'h0);
    assign reg_rd  = acc_ok & rd_en & (addr != 4'h0);
    assign reg_wr  = acc_ok & wr_en & (addr != 4'h0);

    assign xfer      = (bst_q == B_XFER);
    assign fl_act    = (fl_q != 8'h00);
    assign last_byte = (k_q == last_q);
    assign in_rng    = wr_q ? (32'(occ_q) + 32'(k_q) < 32'(BUF_DEPTH))
                            : (32'(k_q) < 32'(occ_q));

    assign get_rx_data   = xfer & ~wr_q & ~fl_act & in_rng;
    assign store_tx_data = xfer & wr_q & ~fl_act & in_rng;
    assign underrun      = xfer & ~wr_q & ~fl_act & ~in_rng;
    assign overflow      = xfer & wr_q & ~fl_act & ~in_rng;
    assign rd_byte       = get_rx_data ? rx_data : 8'h00;
    assign tx_data       = store_tx_data ? wdata[{k_q, 3'b000} +: 8] : 8'h00;

    assign hold        = buf_req | xfer;
    assign rdata       = rdata_q;
    assign rdata_valid = rv_q;
    assign tx_packet   = (tst_q == T_ISSUE) ? txc_q[2:0] : 3'd0;
    assign clear       = clr_q;
    assign d_mode      = tx_transfer_active;
    assign status      = {9'h000, tx_transfer_active, rx_transfer_active, st_q};

    always_comb begin
        reg_rdata = 32'h0;
        case (addr)
            4'h4:    reg_rdata = {16'h0, status};
            4'h6:    reg_rdata = {16'h0, err_q};
            4'h8:    reg_rdata = 32'(buffer_occupancy);
            4'hC:    reg_rdata = {24'h0, txc_q};
            4'hD:    reg_rdata = {24'h0, fl_q};
`ifdef USB_EP_REGFILE_IRQ_EN
            4'hA:    reg_rdata = {16'h0, mask_q};
`endif
            default: reg_rdata = 32'h0;
        endcase
    end

    always_comb begin
        bst_d  = bst_q;
        k_d    = k_q;
        last_d = last_q;
        wr_d   = wr_q;
        occ_d  = occ_q;
        acc_d  = acc_q;
        case (bst_q)
            B_IDLE, B_DONE: begin
                bst_d = B_IDLE;
                if (buf_req) begin
                    bst_d  = B_XFER;
                    k_d    = 2'd0;
                    wr_d   = wr_en;
                    occ_d  = buffer_occupancy;
                    acc_d  = 32'h0;
                    last_d = (size == 2'd0) ? 2'd0 : (size == 2'd1) ? 2'd1 : 2'd3;
                end
            end
            B_XFER: begin
                acc_d[{k_q, 3'b000} +: 8] = rd_byte;
                k_d = k_q + 2'd1;
                if (last_byte) bst_d = B_DONE;
            end
            default: bst_d = B_IDLE;
        endcase
    end

    always_comb begin
        rv_d    = 1'b0;
        rdata_d = rdata_q;
        if (xfer && last_byte && !wr_q) begin
            rv_d    = 1'b1;
            rdata_d = acc_q | (32'(rd_byte) << {k_q, 3'b000});
        end else if (reg_rd) begin
            rv_d    = 1'b1;
            rdata_d = reg_rdata;
        end
    end

    always_comb begin
        st_d = st_q;
        if (rx_data_ready) begin
            st_d[4:1] = 4'h0;
            case (rx_packet)
                3'd1:    st_d[1] = 1'b1;
                3'd2:    st_d[2] = 1'b1;
                3'd3:    st_d[3] = 1'b1;
                3'd4:    st_d[4] = 1'b1;
                default: st_d[4:1] = 4'h0;
            endcase
        end
        if (rx_data_ready && rx_packet == 3'd0) st_d[0] = 1'b1;
        else if (buffer_occupancy == '0)        st_d[0] = 1'b0;
    end

    // Set events override a write-1-to-clear in the same cycle
    always_comb begin
        err_set     = 16'h0;
        err_set[0]  = rx_error;
        err_set[1]  = underrun;
        err_set[8]  = tx_error;
        err_set[9]  = overflow;
        err_set[10] = tx_tmo;
        err_clr     = (reg_wr && addr == 4'h6) ? wdata[15:0] : 16'h0;
        err_d       = (err_q & ~err_clr) | err_set;
    end

    always_comb begin
        tst_d  = tst_q;
        txc_d  = txc_q;
        tmr_d  = tmr_q;
        tx_tmo = 1'b0;
        case (tst_q)
            T_IDLE: begin
                if (reg_wr && addr == 4'hC) begin
                    if (wdata[7:0] == 8'd1 && buffer_occupancy == '0) begin
                        txc_d = 8'h00;
                    end else begin
                        txc_d = wdata[7:0];
                        if (wdata[7:0] >= 8'd1 && wdata[7:0] <= 8'd4) begin
                            tst_d = T_ISSUE;
                            tmr_d = '0;
                        end
                    end
                end
            end
            T_ISSUE: begin
                if (tx_transfer_active) begin
                    tst_d = T_BUSY;
                end else if (tmr_q == TMR_W'(TX_TIMEOUT - 1)) begin
                    tx_tmo = 1'b1;
                    tst_d  = T_IDLE;
                    txc_d  = 8'h00;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            T_BUSY: begin
                if (!tx_transfer_active) begin
                    tst_d = T_IDLE;
                    txc_d = 8'h00;
                end
            end
            default: tst_d = T_IDLE;
        endcase
    end

    // The cycle carrying the clear pulse must not auto-release the flush
    always_comb begin
        fl_d  = fl_q;
        clr_d = 1'b0;
        if (reg_wr && addr == 4'hD && wdata[7:0] != 8'h00) begin
            fl_d  = wdata[7:0];
            clr_d = 1'b1;
        end else if (fl_act && !clr_q && buffer_occupancy == '0) begin
            fl_d = 8'h00;
        end
    end

`ifdef USB_EP_REGFILE_IRQ_EN
    always_comb begin
        mask_d = (reg_wr && addr == 4'hA) ? wdata[15:0] : mask_q;
        irq_d  = |((status | err_q) & mask_q);
    end

    assign irq = irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= 16'h0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bst_q   <= B_IDLE;
            k_q     <= 2'd0;
            last_q  <= 2'd0;
            wr_q    <= 1'b0;
            occ_q   <= '0;
            acc_q   <= 32'h0;
            rdata_q <= 32'h0;
            rv_q    <= 1'b0;
            st_q    <= 5'h0;
            err_q   <= 16'h0;
            tst_q   <= T_IDLE;
            txc_q   <= 8'h00;
            tmr_q   <= '0;
            fl_q    <= 8'h00;
            clr_q   <= 1'b0;
        end else begin
            bst_q   <= bst_d;
            k_q     <= k_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            occ_q   <= occ_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            rv_q    <= rv_d;
            st_q    <= st_d;
            err_q   <= err_d;
            tst_q   <= tst_d;
            txc_q   <= txc_d;
            tmr_q   <= tmr_d;
            fl_q    <= fl_d;
            clr_q   <= clr_d;
        end
    end

endmodule

// File: tb/tb_usb_ep_regfile.sv
// Scoreboard bench for usb_ep_regfile: queued read data and pushed bytes,
// plus cycle-accurate hold/strobe/valid patterns for buffer accesses.
module tb_usb_ep_regfile;

    localparam int BUF_DEPTH  = 64;
    localparam int TX_TIMEOUT = 255;
    localparam int OCC_W      = $clog2(BUF_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             rd_en, wr_en;
    logic [3:0]       addr;
    logic [1:0]       size;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             rdata_valid, hold;
    logic [2:0]       rx_packet;
    logic             rx_data_ready, rx_transfer_active, rx_error;
    logic             tx_transfer_active, tx_error;
    logic [OCC_W-1:0] occ;
    logic [7:0]       rx_data;
    logic             get_rx_data, store_tx_data;
    logic [7:0]       tx_data;
    logic [2:0]       tx_packet;
    logic             clear, d_mode;
`ifdef USB_EP_REGFILE_IRQ_EN
    logic             irq;
`endif

    usb_ep_regfile #(.BUF_DEPTH(BUF_DEPTH), .TX_TIMEOUT(TX_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .size(size),
        .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .hold(hold),
        .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
        .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
        .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
        .buffer_occupancy(occ), .rx_data(rx_data),
        .get_rx_data(get_rx_data), .store_tx_data(store_tx_data),
        .tx_data(tx_data), .tx_packet(tx_packet), .clear(clear),
        .d_mode(d_mode)
`ifdef USB_EP_REGFILE_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] rdq[$];
    logic [7:0]  txq[$];

    logic [7:0] fifo_mem [16];
    logic [3:0] rptr = 4'd0;

    assign rx_data = fifo_mem[rptr];

    always @(posedge clk) if (get_rx_data) rptr <= rptr + 4'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rdata_valid) begin
                chk("rd_pending", 32'(rdq.size() > 0), 32'd1);
                if (rdq.size() > 0) chk("rdata", rdata, rdq.pop_front());
            end
            if (store_tx_data) begin
                chk("tx_pending", 32'(txq.size() > 0), 32'd1);
                if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
            end
        end
    end

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = a; wdata = d; size = 2'd2;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic reg_rd(input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        rd_en = 1'b1; addr = a; size = 2'd2;
        rdq.push_back(exp);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic buf_acc(input string tag, input bit wr, input logic [1:0] sz,
                           input logic [31:0] d, input logic [7:0] exp_stb,
                           input logic [31:0] exp_rd);
        int n;
        logic [7:0] hv, sv, vv, exp_hold;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        hv = '0; sv = '0; vv = '0;
        exp_hold = 8'((1 << (n + 1)) - 1);
        @(negedge clk);
        rd_en = !wr; wr_en = wr; addr = 4'h0; size = sz; wdata = d;
        if (!wr) rdq.push_back(exp_rd);
        #1 hv[0] = hold;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin rd_en = 1'b0; wr_en = 1'b0; end
            hv[c] = hold;
            sv[c] = wr ? store_tx_data : get_rx_data;
            vv[c] = rdata_valid;
        end
        chk({tag, "_hold"}, 32'(hv), 32'(exp_hold));
        chk({tag, "_strobe"}, 32'(sv), 32'(exp_stb));
        if (!wr) chk({tag, "_valid"}, 32'(vv), 32'(1 << (n + 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [7:0] cv;
        fifo_mem = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB, 8'h5A, 8'h66, 8'h77,
                     8'h88, 8'h99, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        rst = 1'b1; rd_en = 0; wr_en = 0; addr = 0; size = 0; wdata = 0;
        rx_packet = 0; rx_data_ready = 0; rx_transfer_active = 0; rx_error = 0;
        tx_transfer_active = 0; tx_error = 0; occ = 0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {24'h0, hold, get_rx_data, store_tx_data, rdata_valid,
                         clear, tx_packet}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        occ = 7'd7;
        reg_rd(4'h6, 32'h0);
        reg_rd(4'h4, 32'h0);
        reg_rd(4'h8, 32'h7);
        reg_rd(4'hA, 32'h0);

        occ = 7'd3;
        @(negedge clk); rx_data_ready = 1; rx_packet = 3'd1;
        @(negedge clk); rx_data_ready = 0;
        reg_rd(4'h4, 32'h2);
        @(negedge clk); rx_data_ready = 1; rx_packet = 3'd0;
        @(negedge clk); rx_data_ready = 0;
        rx_transfer_active = 1;
        reg_rd(4'h4, 32'h21);
        rx_transfer_active = 0;
        @(negedge clk); rx_error = 1;
        @(negedge clk); rx_error = 0;
        reg_rd(4'h6, 32'h1);
        reg_wr(4'h6, 32'h1);
        reg_rd(4'h6, 32'h0);

        occ = 7'd10;
        buf_acc("rd4", 1'b0, 2'd2, 32'h0, 8'h1E, 32'h44332211);
        occ = 7'd1;
        buf_acc("rd2", 1'b0, 2'd1, 32'h0, 8'h02, 32'h000000AB);
        reg_rd(4'h6, 32'h2);
        reg_wr(4'h6, 32'h2);
        reg_rd(4'h6, 32'h0);

        occ = 7'(BUF_DEPTH - 2);
        txq.push_back(8'hAA);
        txq.push_back(8'hBB);
        buf_acc("wr4", 1'b1, 2'd2, 32'hDDCCBBAA, 8'h06, 32'h0);
        reg_rd(4'h6, 32'h200);
        reg_wr(4'h6, 32'h200);
        reg_rd(4'h6, 32'h0);

        occ = 7'd0;
        @(negedge clk); wr_en = 1; addr = 4'hC; wdata = 32'h2;
        @(negedge clk); wr_en = 0;
        chk("tx_issue", 32'(tx_packet), 32'd2);
        repeat (3) @(negedge clk);
        chk("tx_issue_hold", 32'(tx_packet), 32'd2);
        tx_transfer_active = 1;
        @(negedge clk);
        chk("tx_busy_pkt", 32'(tx_packet), 32'd0);
        chk("d_mode", 32'(d_mode), 32'd1);
        reg_rd(4'hC, 32'h2);
        tx_transfer_active = 0;
        repeat (2) @(negedge clk);
        reg_rd(4'hC, 32'h0);

        @(negedge clk); wr_en = 1; addr = 4'hC; wdata = 32'h1;
        @(negedge clk); wr_en = 0;
        chk("tx_reject_pkt", 32'(tx_packet), 32'd0);
        reg_rd(4'hC, 32'h0);
        reg_wr(4'hC, 32'h5);
        chk("tx_code5_pkt", 32'(tx_packet), 32'd0);
        reg_rd(4'hC, 32'h5);
        reg_wr(4'hC, 32'h0);

        @(negedge clk); wr_en = 1; addr = 4'hC; wdata = 32'h3;
        cnt = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) wr_en = 0;
            if (tx_packet != 3'd0) cnt++;
        end
        chk("tx_timeout_len", 32'(cnt), 32'(TX_TIMEOUT));
        reg_rd(4'h6, 32'h400);
        reg_wr(4'h6, 32'h400);
        reg_rd(4'h6, 32'h0);

        occ = 7'd5;
        cv = '0;
        @(negedge clk); wr_en = 1; addr = 4'hD; wdata = 32'h1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) wr_en = 0;
            cv[c] = clear;
        end
        chk("flush_pulse", 32'(cv), 32'h02);
        reg_rd(4'hD, 32'h1);
        buf_acc("flrd", 1'b0, 2'd0, 32'h0, 8'h00, 32'h0);
        occ = 7'd0;
        repeat (2) @(negedge clk);
        reg_rd(4'hD, 32'h0);

        occ = 7'd10;
        @(negedge clk); rd_en = 1; addr = 4'h0; size = 2'd2;
        @(negedge clk); rd_en = 0;
        @(negedge clk);
        chk("mid_hold", 32'(hold), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_outs", {23'h0, hold, get_rx_data, store_tx_data, rdata_valid,
                            clear, d_mode, tx_packet}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        reg_rd(4'h6, 32'h0);
        repeat (2) @(negedge clk);

        chk("rdq_empty", 32'(rdq.size()), 32'd0);
        chk("txq_empty", 32'(txq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
